// File: rtl/mvu_job_seq.sv
// mvu_job_seq: bit-serial job sequencer for one MVU.
// Walks weight/data bit-planes in significance-major order, issues bank read
// addresses under a data-bank grant handshake, and drives the shift-accumulator
// strobes delayed by PIPE_LAT to line up with operand arrival.
// Optional feature macro: MVU_JOB_PERFCNT_EN adds o_stall_cnt (grant-stall cycles).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for i_start
// S_CLR   | one cycle of accumulator clear
// S_ISSUE | issuing reads; schedule advances on each granted request
// S_DRAIN | PIPE_LAT cycles letting the last operands reach the shacc
// S_DONE  | one-cycle done pulse (err when a precision was zero)
module mvu_job_seq #(
    parameter int BWBANKA  = 9,
    parameter int BDBANKA  = 14,
    parameter int BPREC    = 4,
    parameter int BLEN     = 9,
    parameter int PIPE_LAT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [1:0]         i_mode,
    input  logic [BPREC-1:0]   i_iprec,
    input  logic [BPREC-1:0]   i_wprec,
    input  logic [BLEN-1:0]    i_len,
    input  logic [BWBANKA-1:0] i_wbase,
    input  logic [BDBANKA-1:0] i_ibase,
    input  logic               i_rdd_grnt,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [1:0]         o_mul_mode,
    output logic [BWBANKA-1:0] o_rdw_addr,
    output logic               o_rdd_en,
    output logic [BDBANKA-1:0] o_rdd_addr,
    output logic               o_shacc_clr,
    output logic               o_shacc_acc,
    output logic               o_shacc_sh
`ifdef MVU_JOB_PERFCNT_EN
    ,
    output logic [15:0]        o_stall_cnt
`endif
);

    // s spans 0..wprec+iprec-2, one bit wider than a precision
    localparam int SW = BPREC + 1;
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [BPREC-1:0]   r_iprec;
    logic [BPREC-1:0]   r_wprec;
    logic [BLEN-1:0]    r_len;
    logic [BWBANKA-1:0] r_wbase;
    logic [BDBANKA-1:0] r_ibase;
    logic [1:0]         r_mode;
    logic               r_err;

    logic [SW-1:0]      r_s;
    logic [BLEN-1:0]    r_t;
    logic [BPREC-1:0]   r_w;
    logic [BWBANKA-1:0] r_wrow;
    logic [BDBANKA-1:0] r_drow;
    logic               r_sh_pend;
    logic [DW-1:0]      r_drain;

    logic [PIPE_LAT-1:0] r_acc_sr;
    logic [PIPE_LAT-1:0] r_sh_sr;

    logic               w_start_ok;
    logic               w_prec_bad;
    logic               w_accept;
    logic [BPREC-1:0]   w_wlo;
    logic               w_w_end;
    logic               w_t_end;
    logic               w_s_end;
    logic               w_last;
    logic [BPREC-1:0]   w_i;

    // Highest weight bit paired with significance s: min(s, wprec-1)
    function automatic logic [BPREC-1:0] f_whi(input logic [SW-1:0] s,
                                               input logic [BPREC-1:0] wp);
        logic [SW-1:0] lim;
        lim = SW'(wp) - SW'(1);
        return (s > lim) ? BPREC'(lim) : BPREC'(s);
    endfunction

    // Lowest weight bit paired with significance s: max(0, s-iprec+1)
    function automatic logic [BPREC-1:0] f_wlo(input logic [SW-1:0] s,
                                               input logic [BPREC-1:0] ip);
        return (s >= SW'(ip)) ? BPREC'(s - SW'(ip) + SW'(1)) : '0;
    endfunction

    assign w_start_ok = (r_state == S_IDLE) && i_start;
    assign w_prec_bad = (i_iprec == '0) || (i_wprec == '0);
    assign w_accept   = (r_state == S_ISSUE) && i_rdd_grnt;
    assign w_wlo      = f_wlo(r_s, r_iprec);
    assign w_w_end    = (r_w == w_wlo);
    assign w_t_end    = (r_t == r_len - BLEN'(1));
    assign w_s_end    = (r_s == '0);
    assign w_last     = w_accept && w_w_end && w_t_end && w_s_end;
    assign w_i        = BPREC'(r_s - SW'(r_w));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = w_prec_bad ? S_DONE : S_CLR;
            S_CLR:   w_next = (r_len == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (w_last) w_next = S_DRAIN;
            S_DRAIN: if (r_drain == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Job parameters captured on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iprec <= '0;
            r_wprec <= '0;
            r_len   <= '0;
            r_wbase <= '0;
            r_ibase <= '0;
            r_mode  <= '0;
            r_err   <= 1'b0;
        end else if (w_start_ok) begin
            r_iprec <= i_iprec;
            r_wprec <= i_wprec;
            r_len   <= i_len;
            r_wbase <= i_wbase;
            r_ibase <= i_ibase;
            r_mode  <= i_mode;
            r_err   <= w_prec_bad;
        end
    end

    // Schedule walk: w fastest (descending), then tile t, then significance s;
    // tile row offsets are kept as running sums so no multiplier is needed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s       <= '0;
            r_t       <= '0;
            r_w       <= '0;
            r_wrow    <= '0;
            r_drow    <= '0;
            r_sh_pend <= 1'b0;
        end else if (w_start_ok) begin
            r_s       <= SW'(i_wprec) + SW'(i_iprec) - SW'(2);
            r_t       <= '0;
            r_w       <= i_wprec - BPREC'(1);
            r_wrow    <= i_wbase;
            r_drow    <= i_ibase;
            r_sh_pend <= 1'b0;
        end else if (w_accept) begin
            r_sh_pend <= 1'b0;
            if (!w_w_end) begin
                r_w <= r_w - BPREC'(1);
            end else if (!w_t_end) begin
                r_t    <= r_t + BLEN'(1);
                r_w    <= f_whi(r_s, r_wprec);
                r_wrow <= r_wrow + BWBANKA'(r_wprec);
                r_drow <= r_drow + BDBANKA'(r_iprec);
            end else begin
                r_s       <= r_s - SW'(1);
                r_t       <= '0;
                r_w       <= f_whi(r_s - SW'(1), r_wprec);
                r_wrow    <= r_wbase;
                r_drow    <= r_ibase;
                r_sh_pend <= 1'b1;
            end
        end
    end

    // Drain down-counter, loaded on the final accepted issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  r_drain <= '0;
        else if (w_last)                             r_drain <= DW'(PIPE_LAT - 1);
        else if (r_state == S_DRAIN && r_drain != '0) r_drain <= r_drain - DW'(1);
    end

    // Tag delay line so strobes meet the operand at the shacc input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_sr <= '0;
            r_sh_sr  <= '0;
        end else begin
            r_acc_sr <= (r_acc_sr << 1) | PIPE_LAT'(w_accept);
            r_sh_sr  <= (r_sh_sr << 1) | PIPE_LAT'(w_accept && r_sh_pend);
        end
    end

`ifdef MVU_JOB_PERFCNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of requested-but-not-granted cycles for the current job
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  r_stall_cnt <= '0;
        else if (w_start_ok)                         r_stall_cnt <= '0;
        else if (o_rdd_en && !i_rdd_grnt && r_stall_cnt != 16'hFFFF)
                                                     r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_err       = o_done && r_err;
    assign o_mul_mode  = r_mode;
    assign o_rdd_en    = (r_state == S_ISSUE);
    assign o_rdw_addr  = o_rdd_en ? (r_wrow + BWBANKA'(r_w)) : '0;
    assign o_rdd_addr  = o_rdd_en ? (r_drow + BDBANKA'(w_i)) : '0;
    assign o_shacc_clr = (r_state == S_CLR);
    assign o_shacc_acc = r_acc_sr[PIPE_LAT-1];
    assign o_shacc_sh  = r_sh_sr[PIPE_LAT-1];

endmodule
